// File: rtl/stream_fifo_pkg.sv
// Shared streaming constants and helpers used by the stream FIFO and its storage.
package stream_fifo_pkg;

  localparam int DEFAULT_FIFO_DATA_WIDTH  = 32;
  localparam int DEFAULT_FIFO_BUFFER_SIZE = 16;

  // Pointer width carries one extra wrap bit above the array index.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// Register-array storage: synchronous write port, asynchronous read port, contents not reset.
module fifo_mem
  import stream_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_FIFO_DATA_WIDTH,
  parameter int DEPTH = DEFAULT_FIFO_BUFFER_SIZE
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Single-clock first-word-fall-through FIFO; head word is visible combinationally while non-empty.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH  = DEFAULT_FIFO_DATA_WIDTH,
  parameter int FIFO_BUFFER_SIZE = DEFAULT_FIFO_BUFFER_SIZE
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   wr_en,
  input  logic [FIFO_DATA_WIDTH-1:0]             din,
  output logic                                   full,
  input  logic                                   rd_en,
  output logic [FIFO_DATA_WIDTH-1:0]             dout,
  output logic                                   empty,
  output logic [ptr_width(FIFO_BUFFER_SIZE)-1:0] count,
  output logic                                   wr_err,
  output logic                                   rd_err
);

  localparam int ADDR_WIDTH = $clog2(FIFO_BUFFER_SIZE);
  localparam int PTR_WIDTH  = ptr_width(FIFO_BUFFER_SIZE);

  logic [PTR_WIDTH-1:0]       wr_ptr;
  logic [PTR_WIDTH-1:0]       rd_ptr;
  logic [FIFO_DATA_WIDTH-1:0] head;
  logic                       wr_accept;
  logic                       rd_accept;

  // Handshake: a push transfers on an edge where wr_en=1 and full=0; a pop transfers on an
  // edge where rd_en=1 and empty=0. Both flags come from the registered pointers only, so a
  // request against a full/empty FIFO is dropped even if the other side moves that same edge.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                 (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
  assign count = wr_ptr - rd_ptr;

  assign wr_accept = wr_en && !full && !reset;
  assign rd_accept = rd_en && !empty && !reset;

  fifo_mem #(
    .WIDTH (FIFO_DATA_WIDTH),
    .DEPTH (FIFO_BUFFER_SIZE)
  ) u_mem (
    .clock (clock),
    .we    (wr_accept),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (din),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (head)
  );

  // Stale array contents are masked so an empty FIFO always presents zero.
  assign dout = empty ? '0 : head;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      wr_err <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      end
      wr_err <= wr_en && full;
      rd_err <= rd_en && empty;
    end
  end

endmodule
